// File: rtl/mul4_err_sweep_ctrl_if.sv
// Signal bundle between the sweep controller, the test-control side and the multiplier under test.
interface mul4_err_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [7:0]  dut_p;
  logic [3:0]  dut_a;
  logic [3:0]  dut_b;
  logic        busy;
  logic        done;
  logic [8:0]  err_cnt;
  logic [7:0]  max_err;
  logic [3:0]  worst_a;
  logic [3:0]  worst_b;
  logic [15:0] sum_err;

  modport master (
    output start, abort, dut_p,
    input  dut_a, dut_b, busy, done, err_cnt, max_err, worst_a, worst_b, sum_err
  );

  modport slave (
    input  start, abort, dut_p,
    output dut_a, dut_b, busy, done, err_cnt, max_err, worst_a, worst_b, sum_err
  );
endinterface

// File: rtl/mul4_err_sweep_ctrl.sv
// Exhaustive 4x4 multiplier error sweep: launches all 256 operand pairs (a fastest)
// and accumulates error count, max/sum of absolute error and the first worst pair.
module mul4_err_sweep_ctrl #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  mul4_err_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [7:0] idx_r;
  logic [1:0] drain_cnt_r;
  logic [LAT-1:0] vld_r;
  logic [7:0] tag_idx_r [LAT];

  logic [7:0] exact_s;
  logic [7:0] err_s;
  logic       take_s;
  logic       go_s;
  logic       abort_s;

  function automatic logic [7:0] abs_err(input logic [7:0] p, input logic [7:0] x);
    logic signed [8:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, x});
    if (d < 9'sd0) begin
      d = -d;
    end
    return d[7:0];
  endfunction

  // The pair index travels with its valid tag; the exact product is rebuilt at the sample point.
  assign exact_s = {4'd0, tag_idx_r[LAT-1][3:0]} * {4'd0, tag_idx_r[LAT-1][7:4]};
  assign err_s   = abs_err(bus.dut_p, exact_s);
  assign abort_s = bus.abort && (state_r == RUN || state_r == DRAIN);
  assign take_s  = vld_r[LAT-1] && !abort_s;
  assign go_s    = bus.start && (state_r == IDLE || state_r == DONE);

  // Sweep FSM, launch pipeline and metric accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 8'd0;
      drain_cnt_r <= 2'd0;
      vld_r       <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_idx_r[s] <= 8'd0;
      end
      bus.dut_a   <= 4'd0;
      bus.dut_b   <= 4'd0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err_cnt <= 9'd0;
      bus.max_err <= 8'd0;
      bus.worst_a <= 4'd0;
      bus.worst_b <= 4'd0;
      bus.sum_err <= 16'd0;
    end else begin
      for (int s = LAT - 1; s > 0; s--) begin
        vld_r[s]     <= vld_r[s-1];
        tag_idx_r[s] <= tag_idx_r[s-1];
      end
      vld_r[0]     <= 1'b0;
      tag_idx_r[0] <= 8'd0;
      bus.dut_a    <= 4'd0;
      bus.dut_b    <= 4'd0;
      bus.done     <= 1'b0;

      if (take_s && err_s != 8'd0) begin
        bus.err_cnt <= bus.err_cnt + 9'd1;
        bus.sum_err <= bus.sum_err + {8'd0, err_s};
      end
      // Strictly greater keeps the earliest pair on ties
      if (take_s && err_s > bus.max_err) begin
        bus.max_err <= err_s;
        bus.worst_a <= tag_idx_r[LAT-1][3:0];
        bus.worst_b <= tag_idx_r[LAT-1][7:4];
      end

      if (go_s) begin
        state_r      <= RUN;
        bus.busy     <= 1'b1;
        idx_r        <= 8'd1;
        vld_r[0]     <= 1'b1;
        tag_idx_r[0] <= 8'd0;
        bus.err_cnt  <= 9'd0;
        bus.max_err  <= 8'd0;
        bus.worst_a  <= 4'd0;
        bus.worst_b  <= 4'd0;
        bus.sum_err  <= 16'd0;
      end else if (abort_s) begin
        state_r  <= IDLE;
        bus.busy <= 1'b0;
        vld_r    <= '0;
      end else begin
        case (state_r)
          RUN: begin
            bus.dut_a    <= idx_r[3:0];
            bus.dut_b    <= idx_r[7:4];
            vld_r[0]     <= 1'b1;
            tag_idx_r[0] <= idx_r;
            idx_r        <= idx_r + 8'd1;
            if (idx_r == 8'd255) begin
              state_r     <= DRAIN;
              drain_cnt_r <= 2'(LAT - 1);
            end
          end
          DRAIN: begin
            if (drain_cnt_r == 2'd0) begin
              state_r  <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              drain_cnt_r <= drain_cnt_r - 2'd1;
            end
          end
          DONE:    state_r <= IDLE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul4_err_sweep_ctrl.sv
// Bench for mul4_err_sweep_ctrl: LUT-driven multiplier models at LAT=1 and LAT=3,
// table vectors from the characterisation plan, random LUTs against a loop reference.
module tb_mul4_err_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul4_err_sweep_ctrl_if if1();
  mul4_err_sweep_ctrl_if if3();

  mul4_err_sweep_ctrl #(.LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mul4_err_sweep_ctrl #(.LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Multiplier under test: product table indexed by {b, a}
  logic [7:0] prod_lut [256];
  logic [7:0] p3_d1, p3_d2;
  assign if1.dut_p = prod_lut[{if1.dut_b, if1.dut_a}];
  always @(posedge clk) begin
    p3_d1 <= prod_lut[{if3.dut_b, if3.dut_a}];
    p3_d2 <= p3_d1;
  end
  assign if3.dut_p = p3_d2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int mode; int lat; int ec; int mx; int wa; int wb; int sm; int done_cyc;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // f: 0 busy, 1 done, 2 dut_a, 3 dut_b, 4 err_cnt, 5 max_err, 6 worst_a, 7 worst_b, 8 sum_err
  function automatic int obs(input int lat, input int f);
    if (lat == 3) begin
      case (f)
        0: return int'(if3.busy);    1: return int'(if3.done);
        2: return int'(if3.dut_a);   3: return int'(if3.dut_b);
        4: return int'(if3.err_cnt); 5: return int'(if3.max_err);
        6: return int'(if3.worst_a); 7: return int'(if3.worst_b);
        8: return int'(if3.sum_err); default: return -1;
      endcase
    end else begin
      case (f)
        0: return int'(if1.busy);    1: return int'(if1.done);
        2: return int'(if1.dut_a);   3: return int'(if1.dut_b);
        4: return int'(if1.err_cnt); 5: return int'(if1.max_err);
        6: return int'(if1.worst_a); 7: return int'(if1.worst_b);
        8: return int'(if1.sum_err); default: return -1;
      endcase
    end
  endfunction

  task automatic set_start(input int lat, input logic v);
    if (lat == 3) if3.start = v;
    else          if1.start = v;
  endtask

  task automatic check_metrics(input string tag, input int lat, input int ec, input int mx,
                               input int wa, input int wb, input int sm);
    check({tag, ".err_cnt"}, obs(lat, 4), ec);
    check({tag, ".max_err"}, obs(lat, 5), mx);
    check({tag, ".worst_a"}, obs(lat, 6), wa);
    check({tag, ".worst_b"}, obs(lat, 7), wb);
    check({tag, ".sum_err"}, obs(lat, 8), sm);
  endtask

  // 0 exact, 1 tied to zero, 2 exact except (a=3,b=5) -> 240, 3 nonzero products +1
  task automatic fill_lut(input int mode);
    for (int i = 0; i < 256; i++) begin
      int p;
      p = (i % 16) * (i / 16);
      case (mode)
        1:       prod_lut[i] = 8'd0;
        2:       prod_lut[i] = (i == 5 * 16 + 3) ? 8'd240 : 8'(p);
        3:       prod_lut[i] = (p != 0) ? 8'(p + 1) : 8'd0;
        default: prod_lut[i] = 8'(p);
      endcase
    end
  endtask

  // Reference: walk the first n pairs in sweep order using the characterisation rules
  task automatic ref_model(input int n, output int ec, output int mx, output int wa,
                           output int wb, output int sm);
    ec = 0; mx = 0; wa = 0; wb = 0; sm = 0;
    for (int i = 0; i < n; i++) begin
      int e;
      e = int'(prod_lut[i]) - (i % 16) * (i / 16);
      if (e < 0) e = -e;
      if (e != 0) begin ec++; sm += e; end
      if (e > mx) begin mx = e; wa = i % 16; wb = i / 16; end
    end
  endtask

  // Cycle 1 is the cycle after the edge that samples start; returns the done cycle (-1 on timeout)
  task automatic run_sweep(input int lat, output int done_cyc, output int busy_cnt);
    @(negedge clk);
    set_start(lat, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(lat, 1'b0);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      if (obs(lat, 0) == 1) busy_cnt++;
      if (obs(lat, 1) == 1) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int dc, bc, ec, mx, wa, wb, sm, lat, seen, d1, d2, ndone;

    vecs[0] = '{mode: 0, lat: 1, ec: 0,   mx: 0,   wa: 0,  wb: 0,  sm: 0,     done_cyc: 257};
    vecs[1] = '{mode: 1, lat: 1, ec: 225, mx: 225, wa: 15, wb: 15, sm: 14400, done_cyc: 257};
    vecs[2] = '{mode: 2, lat: 1, ec: 1,   mx: 225, wa: 3,  wb: 5,  sm: 225,   done_cyc: 257};
    vecs[3] = '{mode: 2, lat: 3, ec: 1,   mx: 225, wa: 3,  wb: 5,  sm: 225,   done_cyc: 259};
    vecs[4] = '{mode: 3, lat: 1, ec: 225, mx: 1,   wa: 1,  wb: 1,  sm: 225,   done_cyc: 257};

    rst_n = 1'b0;
    if1.start = 1'b0; if1.abort = 1'b0;
    if3.start = 1'b0; if3.abort = 1'b0;
    fill_lut(0);
    repeat (3) @(negedge clk);
    check("reset.busy", obs(1, 0), 0);
    check("reset.done", obs(1, 1), 0);
    check("reset.dut_a", obs(1, 2), 0);
    check("reset.dut_b", obs(1, 3), 0);
    check_metrics("reset", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    foreach (vecs[v]) begin
      fill_lut(vecs[v].mode);
      run_sweep(vecs[v].lat, dc, bc);
      check($sformatf("vec%0d.done_cycle", v), dc, vecs[v].done_cyc);
      check($sformatf("vec%0d.busy_cycles", v), bc, vecs[v].done_cyc - 1);
      check($sformatf("vec%0d.busy_at_done", v), obs(vecs[v].lat, 0), 0);
      check($sformatf("vec%0d.dut_a_at_done", v), obs(vecs[v].lat, 2), 0);
      check_metrics($sformatf("vec%0d", v), vecs[v].lat, vecs[v].ec, vecs[v].mx,
                    vecs[v].wa, vecs[v].wb, vecs[v].sm);
    end

    // Random error tables
    for (int r = 0; r < 4; r++) begin
      lat = (r % 2 == 1) ? 3 : 1;
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 3) == 0) prod_lut[i] = 8'($urandom_range(0, 255));
        else                           prod_lut[i] = 8'((i % 16) * (i / 16));
      end
      ref_model(256, ec, mx, wa, wb, sm);
      run_sweep(lat, dc, bc);
      check($sformatf("rand%0d.done_cycle", r), dc, 256 + lat);
      check_metrics($sformatf("rand%0d", r), lat, ec, mx, wa, wb, sm);
    end

    // Abort in RUN cycle 100: the sample due on the abort edge (pair 99) is discarded
    fill_lut(1);
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    for (int c = 1; c < 100; c++) @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    check("abort.busy", obs(1, 0), 0);
    check("abort.done", obs(1, 1), 0);
    check("abort.dut_a", obs(1, 2), 0);
    check("abort.dut_b", obs(1, 3), 0);
    ref_model(99, ec, mx, wa, wb, sm);
    check_metrics("abort.partial", 1, ec, mx, wa, wb, sm);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (obs(1, 1) == 1) seen = 1;
    end
    check("abort.no_done", seen, 0);
    run_sweep(1, dc, bc);
    check("abort.resweep_done_cycle", dc, 257);
    check_metrics("abort.resweep", 1, 225, 225, 15, 15, 14400);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    for (int c = 1; c < 50; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", obs(1, 0), 0);
    check("midrst.dut_a", obs(1, 2), 0);
    check("midrst.dut_b", obs(1, 3), 0);
    check_metrics("midrst", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst.stays_idle", obs(1, 0), 0);

    // Start pulses during RUN/DRAIN ignored; start held in DONE restarts without a gap
    fill_lut(2);
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    ndone = 0; d1 = -1; d2 = -1;
    for (int c = 1; c <= 600; c++) begin
      if (obs(1, 1) == 1) begin
        ndone++;
        if (ndone == 1) begin
          d1 = c;
          check_metrics("b2b.first", 1, 1, 225, 3, 5, 225);
        end else begin
          d2 = c;
          break;
        end
      end
      if1.start = (c == 30 || c == 200 || c == 256 || (ndone == 1 && c == d1));
      @(negedge clk);
    end
    if1.start = 1'b0;
    check("b2b.first_done_cycle", d1, 257);
    check("b2b.second_done_cycle", d2, 514);
    check_metrics("b2b.second", 1, 1, 225, 3, 5, 225);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
